// File: rtl/image_fitness_pkg.sv
// ============================================================================
// image_fitness_pkg : shared types and width helper for the fitness counter
// Revision: 1.0
// ============================================================================
`default_nettype none

package image_fitness_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits needed to hold a count in the range 0..n inclusive.
    function automatic int fitness_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/image_fitness_counter_popcount_chunk.sv
// ============================================================================
// popcount_chunk : combinational adder-tree population count
// Revision: 1.0
// ============================================================================
`default_nettype none

module popcount_chunk #(
    parameter int Width = 8
) (
    input  logic [Width-1:0]             bits,
    output logic [$clog2(Width+1)-1:0]   count
);

    localparam int OW = $clog2(Width + 1);

    if (Width == 1) begin : g_leaf
        assign count = bits;
    end else begin : g_node
        localparam int LO_W  = Width / 2;
        localparam int HI_W  = Width - LO_W;
        localparam int LO_OW = $clog2(LO_W + 1);
        localparam int HI_OW = $clog2(HI_W + 1);

        logic [LO_OW-1:0] lo_count;
        logic [HI_OW-1:0] hi_count;

        popcount_chunk #(.Width(LO_W)) u_lo (
            .bits  (bits[LO_W-1:0]),
            .count (lo_count)
        );

        popcount_chunk #(.Width(HI_W)) u_hi (
            .bits  (bits[Width-1:LO_W]),
            .count (hi_count)
        );

        assign count = OW'(lo_count) + OW'(hi_count);
    end

endmodule

`default_nettype wire

// File: rtl/image_fitness_counter.sv
// ============================================================================
// image_fitness_counter : multi-cycle matching-pixel count with start/done
// Revision: 1.0
// ============================================================================
`default_nettype none

module image_fitness_counter
    import image_fitness_pkg::*;
#(
    parameter int ImageWidth   = 8,
    parameter int ImageHeight  = 8,
    parameter int BitsPerCycle = 8
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    input  logic [ImageWidth*ImageHeight-1:0]                 result,
    input  logic [ImageWidth*ImageHeight-1:0]                 target,
    output logic                                              busy,
    output logic                                              done,
    output logic [fitness_width(ImageWidth*ImageHeight)-1:0]  fitness,
    output logic                                              perfect
);

    localparam int N  = ImageWidth * ImageHeight;
    localparam int K  = N / BitsPerCycle;
    localparam int FW = fitness_width(N);
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int PW = $clog2(BitsPerCycle + 1);

    if ((N % BitsPerCycle) != 0) begin : g_param_check
        $error("BitsPerCycle must divide ImageWidth*ImageHeight exactly");
    end

    state_t          state;
    state_t          state_next;
    logic [N-1:0]    mask;
    logic [FW-1:0]   acc;
    logic [CW-1:0]   chunk;
    logic [PW-1:0]   chunk_count;
    logic [FW-1:0]   acc_next;
    logic            last_chunk;

    popcount_chunk #(.Width(BitsPerCycle)) u_popcount (
        .bits  (mask[BitsPerCycle-1:0]),
        .count (chunk_count)
    );

    assign acc_next   = acc + FW'(chunk_count);
    assign last_chunk = (chunk == CW'(K - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = COUNT;
            COUNT:   if (last_chunk) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == COUNT);
        done = (state == DONE);
    end

    // Only the low chunk is scored each cycle; the mask shifts down toward it.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask    <= '0;
            acc     <= '0;
            chunk   <= '0;
            fitness <= '0;
            perfect <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask  <= ~(result ^ target);
                        acc   <= '0;
                        chunk <= '0;
                    end
                end
                COUNT: begin
                    acc   <= acc_next;
                    mask  <= mask >> BitsPerCycle;
                    chunk <= chunk + CW'(1);
                    if (last_chunk) begin
                        fitness <= acc_next;
                        perfect <= (acc_next == FW'(N));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_image_fitness_counter.sv
// ============================================================================
// tb_image_fitness_counter : scoreboard bench for image_fitness_counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_image_fitness_counter;

    localparam int K = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [63:0] result_a, target_a, result_b, target_b;
    logic        busy_a, done_a, perfect_a;
    logic        busy_b, done_b, perfect_b;
    logic [6:0]  fitness_a, fitness_b;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] e_a, e_b;
    logic [6:0] held_a = '0;
    logic       prev_rst = 1'b1;

    always #5 clk = ~clk;

    image_fitness_counter #(
        .ImageWidth(8), .ImageHeight(8), .BitsPerCycle(8)
    ) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .result(result_a), .target(target_a),
        .busy(busy_a), .done(done_a), .fitness(fitness_a), .perfect(perfect_a)
    );

    image_fitness_counter #(
        .ImageWidth(8), .ImageHeight(8), .BitsPerCycle(64)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .result(result_b), .target(target_b),
        .busy(busy_b), .done(done_b), .fitness(fitness_b), .perfect(perfect_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor A: scores completions and watches that fitness only moves on done or reset.
    always @(negedge clk) begin
        if (done_a === 1'b1) begin
            if (exp_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done_a actual=1 required=0");
            end else begin
                e_a = exp_a.pop_front();
                check("fitness_a", 32'(fitness_a), 32'(e_a[6:0]));
                check("perfect_a", 32'(perfect_a), 32'(e_a[7]));
            end
        end
        if (done_a === 1'b1 || rst || prev_rst) held_a = fitness_a;
        else check("fitness_hold_a", 32'(fitness_a), 32'(held_a));
        prev_rst = rst;
    end

    always @(negedge clk) begin
        if (done_b === 1'b1) begin
            if (exp_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done_b actual=1 required=0");
            end else begin
                e_b = exp_b.pop_front();
                check("fitness_b", 32'(fitness_b), 32'(e_b[6:0]));
                check("perfect_b", 32'(perfect_b), 32'(e_b[7]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_a();
        int n = 0;
        while (exp_a.size() != 0 && n < 80) begin
            step();
            n++;
        end
        check("drain_a", 32'(exp_a.size()), 32'd0);
    endtask

    // Single start pulse with cycle-exact busy/done checks; fitness goes to the scoreboard.
    task automatic timed_a(input logic [63:0] r, input logic [63:0] t, input logic [7:0] ex);
        exp_a.push_back(ex);
        result_a = r;
        target_a = t;
        start_a  = 1'b1;
        step();
        start_a  = 1'b0;
        for (int c = 1; c <= K + 1; c++) begin
            @(negedge clk);
            check($sformatf("busy_a_c%0d", c), 32'(busy_a), 32'(c <= K));
            check($sformatf("done_a_c%0d", c), 32'(done_a), 32'(c == K + 1));
            step();
        end
        check("queue_a_after_timed", 32'(exp_a.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        result_a = '0; target_a = '0; result_b = '0; target_b = '0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy",    32'(busy_a),    32'd0);
        check("rst_done",    32'(done_a),    32'd0);
        check("rst_fitness", 32'(fitness_a), 32'd0);
        check("rst_perfect", 32'(perfect_a), 32'd0);
        step();

        timed_a(64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5, {1'b1, 7'd64});
        timed_a(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, {1'b0, 7'd0});
        timed_a(64'h25A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5, {1'b0, 7'd63});
        timed_a(64'hA5A5_A5A5_A5A5_A5A4, 64'hA5A5_A5A5_A5A5_A5A5, {1'b0, 7'd63});

        // start held high for 30 cycles: accepts in cycles 0, 10, 20 only.
        repeat (3) exp_a.push_back({1'b0, 7'd32});
        result_a = 64'h0123_4567_89AB_CDEF;
        target_a = 64'h0;
        start_a  = 1'b1;
        repeat (30) step();
        start_a  = 1'b0;
        drain_a();
        repeat (12) step();

        // Extra start pulses and input changes during COUNT/DONE are ignored.
        exp_a.push_back({1'b0, 7'd48});
        result_a = 64'hFFFF_0000_FFFF_0000;
        target_a = 64'hFFFF_FFFF_FFFF_0000;
        start_a  = 1'b1;
        step();
        start_a  = 1'b0;
        step();
        start_a  = 1'b1; result_a = ~result_a;
        step();
        start_a  = 1'b0;
        step();
        step();
        start_a  = 1'b1; target_a = 64'h0;
        step();
        start_a  = 1'b0;
        step(); step(); step();
        start_a  = 1'b1;
        step();
        start_a  = 1'b0;
        drain_a();
        repeat (12) step();

        // Reset in cycle 4 of a count discards it without a done.
        result_a = 64'h0000_0000_0000_00FF;
        target_a = 64'h0;
        start_a  = 1'b1;
        step();
        start_a  = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy",    32'(busy_a),    32'd0);
        check("midrst_done",    32'(done_a),    32'd0);
        check("midrst_fitness", 32'(fitness_a), 32'd0);
        check("midrst_perfect", 32'(perfect_a), 32'd0);
        step();
        repeat (12) step();
        timed_a(64'h0000_0000_0000_00FF, 64'h0, {1'b0, 7'd56});

        // Single-chunk instance: done in cycle 2.
        exp_b.push_back({1'b0, 7'd60});
        result_b = 64'hFF;
        target_b = 64'h0F;
        start_b  = 1'b1;
        step();
        start_b  = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            check($sformatf("busy_b_c%0d", c), 32'(busy_b), 32'(c == 1));
            check($sformatf("done_b_c%0d", c), 32'(done_b), 32'(c == 2));
            step();
        end
        check("queue_b_after_timed", 32'(exp_b.size()), 32'd0);
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/image_fitness_counter.md
# image_fitness_counter

Downstream scoring stage for the evolvable image pipeline. It takes the flattened bitmap produced by the logic unit and a flattened target bitmap, and counts matching pixels (bitwise XNOR) over several cycles. This keeps the popcount narrow, at BitsPerCycle bits per cycle. It returns the count as the fitness value used by the genetic search controller, with a start/busy/done handshake.

## Interface
- ImageWidth, 8, image width in pixels (1 bit per pixel)
- ImageHeight, 8, image height in pixels
- BitsPerCycle, 8, pixels scored per cycle; must divide ImageWidth*ImageHeight exactly
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request scoring; sampled only in IDLE
- result  in  ImageWidth*ImageHeight  candidate image (logic unit output); sampled only on accepted start
- target  in  ImageWidth*ImageHeight  reference image; sampled only on accepted start
- busy  out  1  high while in COUNT
- done  out  1  one-cycle pulse; fitness valid from this cycle onward
- fitness  out  FW = $clog2(N+1), N = ImageWidth*ImageHeight  number of matching pixels, 0..N
- perfect  out  1  fitness == N; updated together with fitness

## Operation
- States: IDLE, COUNT, DONE.
- IDLE with start=1:
  - latch mask = ~(result ^ target) into an N-bit shift register
  - clear accumulator and chunk counter
  - go to COUNT
- COUNT, each cycle:
  - acc += popcount(mask[BitsPerCycle-1:0])
  - mask >>= BitsPerCycle (zero fill)
  - chunk counter +1
  - on the last chunk (K-1, K = N/BitsPerCycle): load fitness with the final sum, load perfect, go to DONE
- DONE: done=1 for exactly one cycle, then unconditionally to IDLE.
- start in COUNT or DONE is ignored, not queued. result/target changes after acceptance have no effect.
- fitness and perfect hold their value until the next completion. They do not change during COUNT.
- Width rules:
  - accumulator and fitness are FW bits and cannot overflow (max N)
  - chunk counter is $clog2(K) bits, minimum 1
  - K=1 is legal: COUNT lasts one cycle
- Reset (any state, including mid-COUNT): state=IDLE, busy=0, done=0, fitness=0, perfect=0, accumulator=0, chunk counter=0, mask=0. A partial count is discarded and no done is issued.
- start and rst high together: reset wins.

## Timing
- Cycle numbering: cycle 0 is the cycle with start=1 in IDLE (edge at end of cycle 0 accepts it).
- busy=1 in cycles 1..K.
- done=1 and fitness/perfect valid in cycle K+1. Latency from start to done is K+1 cycles.
- busy=0 in the done cycle.
- Earliest next accepted start is in cycle K+2, giving throughput of one image per K+2 cycles.
- Default parameters: K=8, so done is high in cycle 9.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package image_fitness_pkg holds:
  - state enum (IDLE, COUNT, DONE) as a 2-bit type
  - function fitness_width(n) returning $clog2(n+1)
- Sub-module popcount_chunk:
  - parameter Width; input [Width-1:0]; output [$clog2(Width+1)-1:0]
  - purely combinational adder tree, one instance in COUNT datapath
- Top level contains the FSM, mask shift register, chunk counter, accumulator and output registers.
- Parameter check: elaboration error if N % BitsPerCycle != 0.

## Test plan
- result == target == 64'hA5A5_A5A5_A5A5_A5A5, start pulse -> busy cycles 1..8, done cycle 9, fitness=64, perfect=1.
- result = 64'h0, target = 64'hFFFF_FFFF_FFFF_FFFF -> fitness=0, perfect=0.
- result and target differ only in bit 63 (last chunk) -> fitness=63, perfect=0; repeat with only bit 0 differing -> 63.
- start held high continuously, and start pulses during busy -> exactly one completion per K+2 cycles; fitness unaffected by result changes during COUNT.
- rst asserted in cycle 4 of COUNT -> next cycle busy=0, fitness=0, no done; a new start then completes normally with the correct count.
- BitsPerCycle=64, result=64'hFF, target=64'h0F -> done in cycle 2, fitness=60.
